// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and constants for the audio DC-block path
package audio_pkg;

  localparam int AUDIO_BIT_WIDTH = 16;
  localparam logic [3:0] GAIN_UNITY = 4'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    MUL  = 2'd2,
    SAT  = 2'd3
  } dcb_state_t;

  typedef logic signed [AUDIO_BIT_WIDTH-1:0] pcm_t;

endpackage

// File: rtl/audio_saturate.sv
// rtl/audio_saturate.sv - combinational signed clamp from IN_W to OUT_W bits with clip flag
module audio_saturate #(
  parameter int IN_W  = 19,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  in_i,
  output logic signed [OUT_W-1:0] out_o,
  output logic                    clip_o
);

  localparam logic signed [IN_W-1:0] MAX_V = IN_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [IN_W-1:0] MIN_V = -MAX_V - IN_W'(1);

  always_comb begin
    out_o  = in_i[OUT_W-1:0];
    clip_o = 1'b0;
    if (in_i > MAX_V) begin
      out_o  = MAX_V[OUT_W-1:0];
      clip_o = 1'b1;
    end else if (in_i < MIN_V) begin
      out_o  = MIN_V[OUT_W-1:0];
      clip_o = 1'b1;
    end
  end

endmodule

// File: rtl/audio_dc_block.sv
// rtl/audio_dc_block.sv - ADC offset-binary to PCM with DC removal, Q2.2 gain, saturation and mute
// Optional: AUDIO_MUTE_RAMP_EN replaces the hard mute with a one-LSB-per-sample gain ramp.
module audio_dc_block #(
  parameter int IN_WIDTH        = 12,
  parameter int AUDIO_BIT_WIDTH = 16,
  parameter int K_SHIFT         = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic [IN_WIDTH-1:0]               in_sample,
  input  logic [3:0]                        gain,
  input  logic                              mute,
  output logic                              out_valid,
  output logic signed [AUDIO_BIT_WIDTH-1:0] out_sample,
  output logic                              clip,
  output logic                              overrun
);

  import audio_pkg::*;

  localparam int ACC_W = AUDIO_BIT_WIDTH + K_SHIFT + 1;
  localparam int Y_W   = AUDIO_BIT_WIDTH + 1;
  localparam int P_W   = Y_W + 4;
  localparam int Q_W   = P_W - 2;

  dcb_state_t                         state_q, state_d;
  logic signed [AUDIO_BIT_WIDTH-1:0]  x_q;
  logic [3:0]                         gain_q;
  logic signed [ACC_W-1:0]            acc_q;
  logic signed [Y_W-1:0]              y_q;
  logic signed [Q_W-1:0]              q_q;
  logic signed [AUDIO_BIT_WIDTH-1:0]  out_sample_q;
  logic                               out_valid_q, clip_q, overrun_q;

  logic signed [AUDIO_BIT_WIDTH-1:0]  x_in;
  logic signed [ACC_W-1:0]            dc, x_ext, y_full;
  logic signed [P_W-1:0]              y_ext, g_ext;
  logic signed [AUDIO_BIT_WIDTH-1:0]  sat_out;
  logic                               sat_clip;
  logic [3:0]                         gain_d;

  // Flipping the MSB turns offset binary into two's complement; left-justify into PCM width.
  assign x_in   = {~in_sample[IN_WIDTH-1], in_sample[IN_WIDTH-2:0],
                   {(AUDIO_BIT_WIDTH-IN_WIDTH){1'b0}}};
  assign dc     = acc_q >>> K_SHIFT;
  assign x_ext  = {{(ACC_W-AUDIO_BIT_WIDTH){x_q[AUDIO_BIT_WIDTH-1]}}, x_q};
  assign y_full = x_ext - dc;
  assign y_ext  = {{(P_W-Y_W){y_q[Y_W-1]}}, y_q};
  assign g_ext  = {{(P_W-4){1'b0}}, gain_q};

`ifdef AUDIO_MUTE_RAMP_EN
  logic [3:0] eff_gain_q;
  logic [3:0] ramp_tgt;

  always_comb begin
    ramp_tgt = mute ? 4'd0 : gain;
    gain_d   = eff_gain_q;
    if (eff_gain_q < ramp_tgt)      gain_d = eff_gain_q + 4'd1;
    else if (eff_gain_q > ramp_tgt) gain_d = eff_gain_q - 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          eff_gain_q <= 4'd0;
    else if (state_q == IDLE && in_valid) eff_gain_q <= gain_d;
  end

  logic mute_q;
  assign mute_q = 1'b0;
`else
  logic mute_q;
  assign gain_d = gain;
`endif

  audio_saturate #(.IN_W(Q_W), .OUT_W(AUDIO_BIT_WIDTH)) u_sat (
    .in_i   (q_q),
    .out_o  (sat_out),
    .clip_o (sat_clip)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = SUB;
      SUB:     state_d = MUL;
      MUL:     state_d = SAT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      x_q          <= '0;
      gain_q       <= '0;
      acc_q        <= '0;
      y_q          <= '0;
      q_q          <= '0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
      clip_q       <= 1'b0;
      overrun_q    <= 1'b0;
`ifndef AUDIO_MUTE_RAMP_EN
      mute_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= 1'b0;
      if (in_valid && state_q != IDLE) overrun_q <= 1'b1;
      case (state_q)
        IDLE: if (in_valid) begin
          x_q    <= x_in;
          gain_q <= gain_d;
`ifndef AUDIO_MUTE_RAMP_EN
          mute_q <= mute;
`endif
        end
        SUB: begin
          y_q   <= y_full[Y_W-1:0];
          acc_q <= acc_q + y_full;
        end
        MUL: q_q <= Q_W'((y_ext * g_ext) >>> 2);
        default: begin
          out_sample_q <= mute_q ? '0 : sat_out;
          clip_q       <= mute_q ? 1'b0 : sat_clip;
          out_valid_q  <= 1'b1;
        end
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;
  assign clip       = clip_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_audio_dc_block.sv
// tb/tb_audio_dc_block.sv - directed and randomized checks of audio_dc_block against an arithmetic model
module tb_audio_dc_block;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic [11:0]        in_sample = 12'h800;
  logic [3:0]         gain = 4'd4;
  logic               mute = 1'b0;
  logic               out_valid;
  logic signed [15:0] out_sample;
  logic               clip;
  logic               overrun;

  int n_checks = 0;
  int n_fail   = 0;
  longint m_acc = 0;
  int     m_eff = 0;
  longint last_out = 0;

  audio_dc_block dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .gain       (gain),
    .mute       (mute),
    .out_valid  (out_valid),
    .out_sample (out_sample),
    .clip       (clip),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint d);
    return (a >= 0) ? a / d : -((-a + d - 1) / d);
  endfunction

  task automatic model_reset();
    m_acc = 0;
    m_eff = 0;
  endtask

  // Mean-tracking high-pass: y = x - floor(acc/256), acc accumulates y, output floor(y*g/4) clamped.
  task automatic model_step(input logic [11:0] s, input int g, input bit m,
                            output longint e_out, output longint e_clip);
    longint x, dc, y, q;
    int gu, tgt;
    tgt = m ? 0 : g;
`ifdef AUDIO_MUTE_RAMP_EN
    if (m_eff < tgt) m_eff++;
    else if (m_eff > tgt) m_eff--;
    gu = m_eff;
`else
    gu = g;
`endif
    x = (longint'(s) - 2048) * 16;
    dc = floor_div(m_acc, 256);
    y = x - dc;
    m_acc += y;
    q = floor_div(y * gu, 4);
    e_clip = 0;
    e_out = q;
    if (q > 32767) begin e_out = 32767; e_clip = 1; end
    else if (q < -32768) begin e_out = -32768; e_clip = 1; end
`ifndef AUDIO_MUTE_RAMP_EN
    if (m) begin e_out = 0; e_clip = 0; end
`endif
  endtask

  task automatic send(input logic [11:0] s, input logic [3:0] g, input bit m, input string tag);
    longint e_out, e_clip;
    int waited;
    model_step(s, int'(g), m, e_out, e_clip);
    @(negedge clk);
    in_valid = 1'b1; in_sample = s; gain = g; mute = m;
    @(negedge clk);
    in_valid = 1'b0;
    waited = 0;
    while (!out_valid && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_latency"}, waited, 3);
    check({tag, "_out"}, $signed(out_sample), e_out);
    check({tag, "_clip"}, clip, e_clip);
    last_out = $signed(out_sample);
    @(negedge clk);
    check({tag, "_pulse"}, out_valid, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int pulses, quiet;
    logic [11:0] pat;
    longint e_out, e_clip;

    // 1: reset state and mid-rail sample
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_out", $signed(out_sample), 0);
    check("rst_clip", clip, 0);
    check("rst_overrun", overrun, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    send(12'h800, 4'd4, 1'b0, "t1_mid");

    // 2: quarter-scale step decays toward zero
    do_reset();
    send(12'hC00, 4'd4, 1'b0, "t2_first");
`ifndef AUDIO_MUTE_RAMP_EN
    check("t2_first_abs", last_out, 16384);
`endif
    for (int i = 1; i < 4096; i++) send(12'hC00, 4'd4, 1'b0, "t2_run");
    check("t2_settled", (last_out <= 64 && last_out >= -64), 1);

    // 3: saturation at both rails
    do_reset();
    send(12'hFFF, 4'd15, 1'b0, "t3_pos");
`ifndef AUDIO_MUTE_RAMP_EN
    check("t3_pos_abs", last_out, 32767);
    check("t3_pos_clip", clip, 1);
`endif
    do_reset();
    send(12'h000, 4'd15, 1'b0, "t3_neg");
`ifndef AUDIO_MUTE_RAMP_EN
    check("t3_neg_abs", last_out, -32768);
    check("t3_neg_clip", clip, 1);
`endif

    // 4: strobes while busy are dropped and set sticky overrun
    do_reset();
    model_step(12'hE00, 4, 1'b0, e_out, e_clip);
    pat = 12'b0000_0000_1011;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) begin
        pulses++;
        check("t4_out", $signed(out_sample), e_out);
      end
      in_valid = pat[i];
      in_sample = (i == 0) ? 12'hE00 : 12'h123;
      gain = 4'd4;
      mute = 1'b0;
    end
    check("t4_pulses", pulses, 1);
    check("t4_overrun", overrun, 1);
    send(12'h900, 4'd4, 1'b0, "t4_after");
    check("t4_overrun_sticky", overrun, 1);

    // 5: reset while the sample is in MUL
    @(negedge clk);
    in_valid = 1'b1; in_sample = 12'hC00; gain = 4'd4; mute = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t5_valid", out_valid, 0);
    check("t5_out", $signed(out_sample), 0);
    check("t5_clip", clip, 0);
    check("t5_overrun", overrun, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    quiet = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) quiet++;
    end
    check("t5_no_valid", quiet, 0);
    send(12'hC00, 4'd4, 1'b0, "t5_next");
`ifndef AUDIO_MUTE_RAMP_EN
    check("t5_next_abs", last_out, 16384);
`endif

    // 6: mute from reset, then release
    do_reset();
    for (int i = 0; i < 5; i++) send(12'hC00, 4'd4, 1'b1, "t6_muted");
    check("t6_muted_zero", last_out, 0);
    for (int i = 0; i < 6; i++) send(12'hC00, 4'd4, 1'b0, "t6_unmute");

    // randomized segments
    for (int seg = 0; seg < 3; seg++) begin
      do_reset();
      for (int i = 0; i < 80; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send(12'($urandom), 4'($urandom), ($urandom_range(0, 5) == 0), "rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
